// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C register-access sequencer.
package i2c_seq_pkg;

    // Sequencer states: one state per byte command plus idle, stop-only and completion.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DEV_W  = 3'd1,
        ST_REG    = 3'd2,
        ST_WDATA  = 3'd3,
        ST_RSTART = 3'd4,
        ST_RDATA  = 3'd5,
        ST_STOP   = 3'd6,
        ST_DONE   = 3'd7
    } seq_state_t;

    // Response status codes.
    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_NACK = 2'd1;
    localparam logic [1:0] ERR_AL   = 2'd2;
    localparam logic [1:0] ERR_TO   = 2'd3;

    // R/W bit appended to the 7-bit device address.
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // Byte-controller command bits, in output order.
    typedef struct packed {
        logic start;
        logic stop;
        logic read;
        logic write;
        logic ack_in;
    } bc_cmd_t;

    localparam bc_cmd_t CMD_NONE     = bc_cmd_t'(5'b00000);
    localparam bc_cmd_t CMD_START_WR = bc_cmd_t'(5'b10010);
    localparam bc_cmd_t CMD_WR       = bc_cmd_t'(5'b00010);
    localparam bc_cmd_t CMD_WR_STOP  = bc_cmd_t'(5'b01010);
    localparam bc_cmd_t CMD_RD_STOP  = bc_cmd_t'(5'b01101);
    localparam bc_cmd_t CMD_STOP     = bc_cmd_t'(5'b01000);

    // Latched register transaction.
    typedef struct packed {
        logic       rnw;
        logic [6:0] dev;
        logic [7:0] reg_addr;
        logic [7:0] wdata;
    } seq_req_t;

    // Address byte as it goes on the wire.
    function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic rw);
        return {dev, rw};
    endfunction

endpackage

// File: rtl/i2c_seq_wdog.sv
// cmd_ack watchdog: counts cycles a command waits, flags expiry at exactly TIMEOUT cycles.
module i2c_seq_wdog #(
    parameter int unsigned           TIMEOUT_W = 20,
    parameter logic [TIMEOUT_W-1:0]  TIMEOUT   = 20'hFFFFF
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic restart,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT - TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] cnt;

    // Count waiting cycles; zero when idle or when a byte completes.
    always_ff @(posedge clk) begin
        if (rst || !active || restart) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + TIMEOUT_W'(1);
        end
    end

    // TIMEOUT of zero disables the watchdog.
    assign expired = active && (TIMEOUT != '0) && (cnt == LAST);

endmodule

// File: rtl/i2c_reg_seq.sv
// Register-access sequencer driving i2c_master_byte_ctrl through a complete I2C frame.
module i2c_reg_seq
    import i2c_seq_pkg::*;
#(
    parameter int unsigned          TIMEOUT_W = 20,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 20'hFFFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rnw,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [1:0] rsp_err,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       bc_start,
    output logic       bc_stop,
    output logic       bc_read,
    output logic       bc_write,
    output logic       bc_ack_in,
    output logic [7:0] bc_din,
    input  logic       bc_cmd_ack,
    input  logic       bc_ack_out,
    input  logic [7:0] bc_dout,
    input  logic       bc_al
);

    seq_state_t state;
    seq_req_t   req_q;
    bc_cmd_t    cmd_q;
    logic       wd_active;
    logic       wd_expired;

    assign bc_start  = cmd_q.start;
    assign bc_stop   = cmd_q.stop;
    assign bc_read   = cmd_q.read;
    assign bc_write  = cmd_q.write;
    assign bc_ack_in = cmd_q.ack_in;

    // A byte command is outstanding in every state except IDLE and DONE.
    assign wd_active = (state != ST_IDLE) && (state != ST_DONE);

    i2c_seq_wdog #(
        .TIMEOUT_W (TIMEOUT_W),
        .TIMEOUT   (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .active  (wd_active),
        .restart (bc_cmd_ack),
        .expired (wd_expired)
    );

    // Frame sequencer with registered byte commands and response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            req_q     <= '0;
            cmd_q     <= CMD_NONE;
            bc_din    <= 8'h00;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= ERR_OK;
            rsp_rdata <= 8'h00;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_q     <= {req_rnw, req_dev, req_reg, req_wdata};
                        state     <= ST_DEV_W;
                        cmd_q     <= CMD_START_WR;
                        bc_din    <= addr_byte(req_dev, RW_WRITE);
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    if (bc_al) begin
                        // Lost the bus: abandon without a stop.
                        state     <= ST_DONE;
                        cmd_q     <= CMD_NONE;
                        bc_din    <= 8'h00;
                        rsp_valid <= 1'b1;
                        rsp_err   <= ERR_AL;
                    end else if (bc_cmd_ack) begin
                        case (state)
                            ST_DEV_W, ST_RSTART: begin
                                if (bc_ack_out) begin
                                    state  <= ST_STOP;
                                    cmd_q  <= CMD_STOP;
                                    bc_din <= 8'h00;
                                end else if (state == ST_DEV_W) begin
                                    state  <= ST_REG;
                                    cmd_q  <= CMD_WR;
                                    bc_din <= req_q.reg_addr;
                                end else begin
                                    state  <= ST_RDATA;
                                    cmd_q  <= CMD_RD_STOP;
                                    bc_din <= 8'h00;
                                end
                            end
                            ST_REG: begin
                                if (bc_ack_out) begin
                                    state  <= ST_STOP;
                                    cmd_q  <= CMD_STOP;
                                    bc_din <= 8'h00;
                                end else if (req_q.rnw) begin
                                    state  <= ST_RSTART;
                                    cmd_q  <= CMD_START_WR;
                                    bc_din <= addr_byte(req_q.dev, RW_READ);
                                end else begin
                                    state  <= ST_WDATA;
                                    cmd_q  <= CMD_WR_STOP;
                                    bc_din <= req_q.wdata;
                                end
                            end
                            ST_WDATA: begin
                                state     <= ST_DONE;
                                cmd_q     <= CMD_NONE;
                                bc_din    <= 8'h00;
                                rsp_valid <= 1'b1;
                                rsp_err   <= bc_ack_out ? ERR_NACK : ERR_OK;
                            end
                            ST_RDATA: begin
                                state     <= ST_DONE;
                                cmd_q     <= CMD_NONE;
                                bc_din    <= 8'h00;
                                rsp_valid <= 1'b1;
                                rsp_err   <= ERR_OK;
                                rsp_rdata <= bc_dout;
                            end
                            ST_STOP: begin
                                state     <= ST_DONE;
                                cmd_q     <= CMD_NONE;
                                bc_din    <= 8'h00;
                                rsp_valid <= 1'b1;
                                rsp_err   <= ERR_NACK;
                            end
                            default: begin
                                state <= ST_IDLE;
                                cmd_q <= CMD_NONE;
                            end
                        endcase
                    end else if (wd_expired) begin
                        state     <= ST_DONE;
                        cmd_q     <= CMD_NONE;
                        bc_din    <= 8'h00;
                        rsp_valid <= 1'b1;
                        rsp_err   <= ERR_TO;
                    end
                end
            endcase
        end
    end

endmodule
